// File: rtl/bsk_mgr_pkg.sv
// Shared bsk_mgr parameters and types: number of parallel BSK cuts and the
// cut dispatcher FSM state encoding.
package bsk_mgr_pkg;

   localparam int BSK_CUT_NB = 4;

   typedef enum logic [1:0] {
      CUT_ST_IDLE  = 2'd0,
      CUT_ST_FILL  = 2'd1,
      CUT_ST_FLUSH = 2'd2
   } cut_disp_state_e;

endpackage

// File: rtl/bsk_mgr_cut_dispatch.sv
// Spreads a stream of BSK words round-robin over BSK_CUT_NB cut RAMs, one
// registered write per accepted word. Optional sticky protocol error under BSK_MGR_CUT_DISPATCH_ERR_EN.
module bsk_mgr_cut_dispatch #(
   parameter int  BSK_CUT_NB = bsk_mgr_pkg::BSK_CUT_NB,
   parameter int  DATA_W     = 64,
   parameter int  CUT_DEPTH  = 256,
   localparam int CUT_ADD_W  = $clog2(CUT_DEPTH)
) (
   input  logic                  clk,
   input  logic                  a_rst,
   input  logic                  start,
   input  logic [CUT_ADD_W:0]    word_per_cut,
   input  logic [DATA_W-1:0]     in_data,
   input  logic                  in_vld,
   output logic                  in_rdy,
   output logic [BSK_CUT_NB-1:0] cut_wr_en,
   output logic [CUT_ADD_W-1:0]  cut_wr_add,
   output logic [DATA_W-1:0]     cut_wr_data,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);
   import bsk_mgr_pkg::*;

   localparam int IDX_W = (BSK_CUT_NB > 1) ? $clog2(BSK_CUT_NB) : 1;
   localparam int CNT_W = CUT_ADD_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(CUT_DEPTH);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BSK_CUT_NB - 1);

   cut_disp_state_e       state_q, state_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [CUT_ADD_W-1:0]  add_q, add_d;
   logic [CNT_W-1:0]      wpc_q, wpc_d;
   logic [CNT_W-1:0]      wpc_clamp;
   logic [BSK_CUT_NB-1:0] wr_en_q, wr_en_d;
   logic [CUT_ADD_W-1:0]  wr_add_q;
   logic [DATA_W-1:0]     wr_data_q;
   logic                  accept;
   logic                  last_word;
   logic                  launch;

   assign wpc_clamp = (word_per_cut > DEPTH_C) ? DEPTH_C : word_per_cut;
   assign accept    = in_vld && in_rdy;
   assign launch    = (state_q == CUT_ST_IDLE) && start;
   // Last word: final cut of the final address row (wpc_q >= 1 whenever in FILL).
   assign last_word = (idx_q == IDX_LAST) && ({1'b0, add_q} == (wpc_q - CNT_W'(1)));

   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) state_q <= CUT_ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         CUT_ST_IDLE:  if (start) state_d = (wpc_clamp == '0) ? CUT_ST_FLUSH : CUT_ST_FILL;
         CUT_ST_FILL:  if (accept && last_word) state_d = CUT_ST_FLUSH;
         CUT_ST_FLUSH: state_d = CUT_ST_IDLE;
         default:      state_d = CUT_ST_IDLE;
      endcase
   end

   always_comb begin
      in_rdy = (state_q == CUT_ST_FILL);
      busy   = (state_q != CUT_ST_IDLE);
      done   = (state_q == CUT_ST_FLUSH);
   end

   // Cut index wraps and carries into the address, replacing k mod / k div.
   always_comb begin
      idx_d = idx_q;
      add_d = add_q;
      wpc_d = wpc_q;
      if (launch) begin
         idx_d = '0;
         add_d = '0;
         wpc_d = wpc_clamp;
      end else if (accept) begin
         if (idx_q == IDX_LAST) begin
            idx_d = '0;
            add_d = add_q + CUT_ADD_W'(1);
         end else begin
            idx_d = idx_q + IDX_W'(1);
         end
      end
   end

   assign wr_en_d = accept ? (BSK_CUT_NB'(1) << idx_q) : '0;

   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) begin
         idx_q     <= '0;
         add_q     <= '0;
         wpc_q     <= '0;
         wr_en_q   <= '0;
         wr_add_q  <= '0;
         wr_data_q <= '0;
      end else begin
         idx_q   <= idx_d;
         add_q   <= add_d;
         wpc_q   <= wpc_d;
         wr_en_q <= wr_en_d;
         if (accept) begin
            wr_add_q  <= add_q;
            wr_data_q <= in_data;
         end
      end
   end

   assign cut_wr_en   = wr_en_q;
   assign cut_wr_add  = wr_add_q;
   assign cut_wr_data = wr_data_q;

`ifdef BSK_MGR_CUT_DISPATCH_ERR_EN
   logic err_q, err_d;

   assign err_d = err_q || (start && busy) || (in_vld && (state_q == CUT_ST_IDLE));

   always_ff @(posedge clk or posedge a_rst) begin
      if (a_rst) err_q <= 1'b0;
      else       err_q <= err_d;
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bsk_mgr_cut_dispatch.sv
// Directed bench for bsk_mgr_cut_dispatch: table of dispatch scenarios plus
// hand sequences for restart-while-busy, idle in_vld and reset mid-fill.
module tb_bsk_mgr_cut_dispatch;

   localparam int NB     = 4;
   localparam int DW     = 64;
   localparam int DEPTH  = 256;
   localparam int AW     = 8;
   localparam int CW     = AW + 1;
   localparam int EW     = NB + AW + DW;
`ifdef BSK_MGR_CUT_DISPATCH_ERR_EN
   localparam logic ERR_EXP = 1'b1;
`else
   localparam logic ERR_EXP = 1'b0;
`endif

   typedef struct {
      int wpc;
      bit gap;
      int restart_at;
      int exp_writes;
      int exp_busy;
      int exp_last_add;
   } vec_t;

   logic          clk = 1'b0;
   logic          a_rst = 1'b0;
   logic          start = 1'b0;
   logic [CW-1:0] word_per_cut = '0;
   logic [DW-1:0] in_data = '0;
   logic          in_vld = 1'b0;
   logic          in_rdy;
   logic [NB-1:0] cut_wr_en;
   logic [AW-1:0] cut_wr_add;
   logic [DW-1:0] cut_wr_data;
   logic          busy;
   logic          done;
   logic          err;

   int n_vec = 0;
   int n_err = 0;

   logic [EW-1:0] exp_q[$];
   int            busy_cnt, done_cnt, wr_cnt, last_add;
   bit            rdy_seen, done_with_wr;

   bsk_mgr_cut_dispatch #(.BSK_CUT_NB(NB), .DATA_W(DW), .CUT_DEPTH(DEPTH)) dut (
      .clk(clk), .a_rst(a_rst), .start(start), .word_per_cut(word_per_cut),
      .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
      .cut_wr_en(cut_wr_en), .cut_wr_add(cut_wr_add), .cut_wr_data(cut_wr_data),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] mk_data(input int s, input int k);
      return {32'(s * 1000 + 7), 32'(k) ^ 32'h5a5a_0000};
   endfunction

   function automatic logic [EW-1:0] mk_exp(input int s, input int k);
      logic [NB-1:0] oh;
      oh = '0;
      oh[k % NB] = 1'b1;
      return {oh, AW'(k / NB), mk_data(s, k)};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_mon();
      busy_cnt = 0; done_cnt = 0; wr_cnt = 0; last_add = -1;
      rdy_seen = 0; done_with_wr = 0;
   endtask

   // Scoreboard: every issued write must match the head of the expected queue.
   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (busy) busy_cnt++;
      if (in_rdy) rdy_seen = 1;
      if (done) begin
         done_cnt++;
         if (cut_wr_en != '0) done_with_wr = 1;
      end
      if (cut_wr_en != '0) begin
         wr_cnt++;
         last_add = int'(cut_wr_add);
         n_vec++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL write: unexpected en=%b add=%0d data=%0h", cut_wr_en, cut_wr_add, cut_wr_data);
         end else begin
            e = exp_q.pop_front();
            if ({cut_wr_en, cut_wr_add, cut_wr_data} !== e) begin
               n_err++;
               $display("FAIL write: got en=%b add=%0d data=%0h expected en=%b add=%0d data=%0h",
                        cut_wr_en, cut_wr_add, cut_wr_data, e[EW-1 -: NB], e[DW +: AW], e[DW-1:0]);
            end
         end
      end
   end

   task automatic pulse_reset();
      a_rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 a_rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Caller is at posedge+1. Sends up to n_send words, returns how many were accepted.
   task automatic drive(input vec_t v, input int s, input int n_send, output int k);
      int  c;
      bit  acc, restarted;
      k = 0; c = 0; restarted = 0;
      start = 1'b1;
      word_per_cut = CW'(v.wpc);
      @(posedge clk);
      #1 start = 1'b0;
      while (k < n_send && c < 4 * n_send + 20) begin
         in_vld  = v.gap ? (c % 2 == 0) : 1'b1;
         in_data = mk_data(s, k);
         if (k == v.restart_at && !restarted) begin
            start = 1'b1;
            word_per_cut = CW'(1);
            restarted = 1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         acc = in_vld && in_rdy;
         @(posedge clk);
         #1;
         if (acc) k++;
         c++;
      end
      in_vld = 1'b0;
      start  = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int s);
      int k;
      for (int j = 0; j < v.exp_writes; j++) exp_q.push_back(mk_exp(s, j));
      clear_mon();
      drive(v, s, v.exp_writes, k);
      chk($sformatf("v%0d accepted", s), 64'(k), 64'(v.exp_writes));
      repeat (4) @(posedge clk);
      #1;
      chk($sformatf("v%0d writes", s), 64'(wr_cnt), 64'(v.exp_writes));
      chk($sformatf("v%0d done_cnt", s), 64'(done_cnt), 64'd1);
      chk($sformatf("v%0d done_with_wr", s), 64'(done_with_wr), 64'(v.exp_writes > 0));
      chk($sformatf("v%0d busy_cycles", s), 64'(busy_cnt), 64'(v.exp_busy));
      chk($sformatf("v%0d rdy_seen", s), 64'(rdy_seen), 64'(v.exp_writes > 0));
      if (v.exp_writes > 0)
         chk($sformatf("v%0d last_add", s), 64'(last_add), 64'(v.exp_last_add));
      chk($sformatf("v%0d exp_q_left", s), 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   initial begin
      vec_t vecs[7];
      vec_t v;
      int   k;

      vecs[0] = '{wpc: 2,   gap: 0, restart_at: -1, exp_writes: 8,    exp_busy: 9,    exp_last_add: 1};
      vecs[1] = '{wpc: 2,   gap: 1, restart_at: -1, exp_writes: 8,    exp_busy: 16,   exp_last_add: 1};
      vecs[2] = '{wpc: 0,   gap: 0, restart_at: -1, exp_writes: 0,    exp_busy: 1,    exp_last_add: 0};
      vecs[3] = '{wpc: 1,   gap: 0, restart_at: -1, exp_writes: 4,    exp_busy: 5,    exp_last_add: 0};
      vecs[4] = '{wpc: 261, gap: 0, restart_at: -1, exp_writes: 1024, exp_busy: 1025, exp_last_add: 255};
      vecs[5] = '{wpc: 511, gap: 1, restart_at: -1, exp_writes: 1024, exp_busy: 2048, exp_last_add: 255};
      vecs[6] = '{wpc: 3,   gap: 0, restart_at: 2,  exp_writes: 12,   exp_busy: 13,   exp_last_add: 2};

      // Outputs while reset is held, before any clock edge.
      #1 a_rst = 1'b1;
      #2;
      chk("rst in_rdy", 64'(in_rdy), 64'd0);
      chk("rst busy", 64'(busy), 64'd0);
      chk("rst done", 64'(done), 64'd0);
      chk("rst err", 64'(err), 64'd0);
      chk("rst cut_wr_en", 64'(cut_wr_en), 64'd0);
      @(posedge clk);
      #1 a_rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 7; i++) run_vec(vecs[i], i);
      chk("restart err", 64'(err), 64'(ERR_EXP));

      // in_vld while idle: no writes, never ready.
      pulse_reset();
      chk("post-reset err", 64'(err), 64'd0);
      clear_mon();
      in_vld = 1'b1;
      in_data = 64'hdead_beef_0000_0001;
      repeat (3) @(posedge clk);
      #1 in_vld = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("idle_vld writes", 64'(wr_cnt), 64'd0);
      chk("idle_vld rdy_seen", 64'(rdy_seen), 64'd0);
      chk("idle_vld busy", 64'(busy_cnt), 64'd0);
      chk("idle_vld err", 64'(err), 64'(ERR_EXP));

      // Reset after 5 of 8 words: 5th write is killed before it shows.
      pulse_reset();
      clear_mon();
      for (int j = 0; j < 5; j++) exp_q.push_back(mk_exp(20, j));
      v = vecs[0];
      drive(v, 20, 5, k);
      chk("midrst accepted", 64'(k), 64'd5);
      #1 a_rst = 1'b1;
      #1;
      chk("midrst cut_wr_en", 64'(cut_wr_en), 64'd0);
      chk("midrst busy", 64'(busy), 64'd0);
      chk("midrst in_rdy", 64'(in_rdy), 64'd0);
      chk("midrst done", 64'(done), 64'd0);
      repeat (2) @(posedge clk);
      #1 a_rst = 1'b0;
      chk("midrst writes", 64'(wr_cnt), 64'd4);
      chk("midrst done_cnt", 64'(done_cnt), 64'd0);
      chk("midrst exp_q_left", 64'(exp_q.size()), 64'd1);
      exp_q.delete();
      @(posedge clk);
      #1;
      run_vec(vecs[3], 21);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/bsk_mgr_cut_dispatch.md
BSK_MGR_CUT_DISPATCH -- requirements
Module: bsk_mgr_cut_dispatch

Interface
REQ-001 SHALL have parameter BSK_CUT_NB, default taken from the shared package (4), meaning the number of BSK cuts fed in parallel.
REQ-002 SHALL have parameter DATA_W, default 64, meaning the width of one BSK word.
REQ-003 SHALL have parameter CUT_DEPTH, default 256, meaning the maximum number of words per cut RAM; CUT_ADD_W = $clog2(CUT_DEPTH).
REQ-004 clk  input  1  clock; the only clock in the block.
REQ-005 a_rst  input  1  reset; asynchronous, active-high.
REQ-006 start  input  1  single-cycle pulse that launches one dispatch.
REQ-007 word_per_cut  input  CUT_ADD_W+1  words to write into each cut; sampled on start.
REQ-008 in_data  input  DATA_W  incoming BSK word.
REQ-009 in_vld  input  1  in_data is valid.
REQ-010 in_rdy  output  1  block accepts in_data.
REQ-011 cut_wr_en  output  BSK_CUT_NB  one-hot write enable, one bit per cut RAM.
REQ-012 cut_wr_add  output  CUT_ADD_W  write address, shared by all cuts.
REQ-013 cut_wr_data  output  DATA_W  write data, shared by all cuts.
REQ-014 busy  output  1  a dispatch is in progress.
REQ-015 done  output  1  single-cycle pulse when the last write has been issued.
REQ-016 err  output  1  sticky protocol error (present only with the macro in REQ-032).

Function
REQ-017 SHALL implement FSM states IDLE, FILL and FLUSH.
- IDLE -> FILL on start when word_per_cut != 0.
- IDLE -> FLUSH on start when word_per_cut == 0.
- FILL -> FLUSH on acceptance of the last word.
- FLUSH -> IDLE after one cycle.
REQ-018 SHALL accept a word when in_vld && in_rdy; in_rdy SHALL be 1 only in FILL.
REQ-019 SHALL route accepted word k (k = 0..word_per_cut*BSK_CUT_NB-1) to cut k mod BSK_CUT_NB, at address k / BSK_CUT_NB.
REQ-020 SHALL track position with a cut index counter (0..BSK_CUT_NB-1) that wraps to 0 and increments the address counter on wrap; no divider SHALL be used.
REQ-021 SHALL register writes with a fixed latency of 1 cycle: an accepted word at cycle N drives cut_wr_en/add/data at cycle N+1.
REQ-022 cut_wr_en SHALL be all-zero in cycles with no accepted word the previous cycle; cut_wr_add/cut_wr_data are don't-care when cut_wr_en == 0.
REQ-023 done SHALL pulse in the FLUSH cycle, coincident with the last write; for word_per_cut == 0, done SHALL pulse without any write.
REQ-024 busy SHALL be 1 from the cycle after start until and including the done cycle.
REQ-025 SHALL ignore start while busy; the dispatch in progress SHALL continue unaffected.
REQ-026 SHALL ignore in_vld outside FILL (in_rdy = 0); no write SHALL result.
REQ-027 word_per_cut > CUT_DEPTH SHALL be clamped to CUT_DEPTH.

Reset
REQ-028 On a_rst assertion, SHALL immediately (asynchronously) force:
- FSM to IDLE;
- both counters to 0;
- in_rdy, busy, done, err and cut_wr_en to 0.
REQ-029 Reset mid-FILL SHALL abort the dispatch with no done pulse and no further writes.
REQ-030 SHALL require only one clock edge after a_rst deasserts before accepting start.

Configuration
REQ-031 Exactly one compile-time option.
REQ-032 With BSK_MGR_CUT_DISPATCH_ERR_EN defined, err SHALL set one cycle after either of:
- start while busy;
- in_vld while in IDLE.
err SHALL hold until a_rst. Without the macro, err SHALL be tied to 0 and no detection logic SHALL be built.

Structure
REQ-033 BSK_CUT_NB SHALL come from the shared bsk_mgr common parameter package; the FSM state enum type SHALL be defined in that package.
REQ-034 No sub-module; the output register stage stays inline.

Verification
REQ-035 BSK_CUT_NB=4, word_per_cut=2, 8 words D0..D7 sent back-to-back -> writes at cut0@0=D0, cut1@0=D1, cut2@0=D2, cut3@0=D3, cut0@1=D4 ... cut3@1=D7; done coincides with the D7 write.
REQ-036 Same test with in_vld toggled 1/0 each cycle -> identical write sequence; cut_wr_en = 0 in gap cycles.
REQ-037 word_per_cut=0 -> busy for 1 cycle, done pulses, no cut_wr_en asserted, in_rdy never 1.
REQ-038 start pulsed again on the 3rd word of a word_per_cut=3 dispatch -> ignored; 12 writes total; err=1 only with the macro defined.
REQ-039 a_rst asserted after 5 of 8 words -> outputs 0 immediately, no done; a new start then writes from cut0@0.
REQ-040 word_per_cut=CUT_DEPTH+5 -> exactly CUT_DEPTH*BSK_CUT_NB writes; last address = CUT_DEPTH-1.
